mem_arbiter: RTL and testbench

- Shares the single RAM port between the instruction-fetch requester and the data-memory requester of the pipelined CPU.
- Sequences each access with a registered FSM and returns completion as a one-cycle wait-low pulse to the winning requester.
- Data requests win by default. A streak counter stops data traffic from starving fetch. A timeout counter aborts a hung RAM transaction and flags the error.
- Sits between the fetch/memory stages and the RAM model. The hazard unit consumes iwait/dwait indirectly through ihit/dhit.

---
 rtl/mem_arbiter_pkg.sv | 28 ++
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter_streak_ctr.sv | 28 ++
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data RAM-port arbiter: word, RAM handshake state,
// arbiter FSM state and the latched request payload.
package mem_arbiter_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } arb_state_t;

  typedef struct packed {
    word_t addr;
    word_t store;
    logic  wen;
  } arb_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU-side request/response signals and RAM-side port of the arbiter in one bundle.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  // Arbiter view
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  // Environment view (requesters + RAM)
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/mem_arbiter_streak_ctr.sv
// Saturating count of consecutive data grants taken while fetch was waiting.
module arb_streak_ctr #(
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic CLK,
  input  logic nRST,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_sat_c
);

  localparam int unsigned CNT_W = $clog2(MAX_DSTREAK + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !o_sat_c) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_sat_c = (r_cnt == CNT_W'(MAX_DSTREAK));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single RAM port between fetch and data requesters: data-first with
// an anti-starvation streak limit, one-cycle wait-low completion, and a hung-RAM timeout.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus,
  output logic          mem_err
);

  localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

  arb_state_t        r_state;
  arb_req_t          r_req;
  logic [TCNT_W-1:0] r_tcount;
  logic              r_ren;
  logic              r_wen;
  logic              r_mem_err;

  logic w_dreq;
  logic w_sat;
  logic w_grant_d;
  logic w_grant_i;
  logic w_active;
  logic w_access;
  logic w_timeout;
  logic w_done;
  logic w_ipulse;
  logic w_dpulse;

  // Fetch is forced only when it has waited through a full streak of data grants
  assign w_dreq    = bus.dREN | bus.dWEN;
  assign w_grant_d = (r_state == IDLE) && w_dreq && !(bus.iREN && w_sat);
  assign w_grant_i = (r_state == IDLE) && !w_grant_d && bus.iREN;
  assign w_active  = (r_state == IACC) || (r_state == DACC);
  assign w_access  = w_active && (bus.ramstate == ACCESS);
  assign w_timeout = w_active && !w_access && (r_tcount == TCNT_W'(TIMEOUT - 1));

  arb_streak_ctr #(
    .MAX_DSTREAK (MAX_DSTREAK)
  ) u_streak (
    .CLK     (CLK),
    .nRST    (nRST),
    .i_clr   (w_grant_i || (w_grant_d && !bus.iREN)),
    .i_inc   (w_grant_d && bus.iREN),
    .o_sat_c (w_sat)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_req     <= '0;
      r_tcount  <= '0;
      r_ren     <= 1'b0;
      r_wen     <= 1'b0;
      r_mem_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_tcount <= '0;
          if (w_grant_d) begin
            r_state     <= DACC;
            r_req.addr  <= bus.daddr;
            r_req.store <= bus.dstore;
            r_req.wen   <= bus.dWEN;
            r_ren       <= !bus.dWEN;
            r_wen       <= bus.dWEN;
          end else if (w_grant_i) begin
            r_state    <= IACC;
            r_req.addr <= bus.iaddr;
            r_req.wen  <= 1'b0;
            r_ren      <= 1'b1;
            r_wen      <= 1'b0;
          end
        end
        IACC, DACC: begin
          // FREE/BUSY/ERROR all simply hold the RAM drive and keep counting
          if (w_access || w_timeout) begin
            r_state <= IDLE;
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
            if (w_timeout) begin
              r_mem_err <= 1'b1;
            end
          end else begin
            r_tcount <= r_tcount + TCNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_ren   <= 1'b0;
          r_wen   <= 1'b0;
        end
      endcase
    end
  end

  // Completion is reported only to a requester still asking, and never during reset
  assign w_done   = w_access && nRST;
  assign w_ipulse = w_done && (r_state == IACC) && bus.iREN;
  assign w_dpulse = w_done && (r_state == DACC) && w_dreq;

  assign bus.iwait    = !w_ipulse;
  assign bus.iload    = w_ipulse ? bus.ramload : '0;
  assign bus.dwait    = !w_dpulse;
  assign bus.dload    = (w_dpulse && !r_req.wen) ? bus.ramload : '0;
  assign bus.ramREN   = r_ren;
  assign bus.ramWEN   = r_wen;
  assign bus.ramaddr  = r_req.addr;
  assign bus.ramstore = r_req.store;
  assign mem_err      = r_mem_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter with a latency/hang-configurable RAM model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic CLK;
  logic nRST;
  logic mem_err;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .MAX_DSTREAK (4),
    .TIMEOUT     (8)
  ) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .bus     (bus.slave),
    .mem_err (mem_err)
  );

  typedef struct {
    bit          is_d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          streak;
  } exp_t;

  exp_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;
  int cnt_ren  = 0;
  int cnt_wen  = 0;
  int cnt_ilow = 0;
  int cnt_dlow = 0;

  int ram_lat  = 0;
  bit ram_hang = 0;
  int ram_cnt  = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'h2402_0045;
  endfunction

  // RAM model: ACCESS after ram_lat BUSY cycles of continuous enable, unless hung
  always @(posedge CLK) begin
    if (bus.ramREN || bus.ramWEN) ram_cnt <= ram_cnt + 1;
    else                          ram_cnt <= 0;
  end
  assign bus.ramstate = !(bus.ramREN || bus.ramWEN) ? FREE :
                        (!ram_hang && ram_cnt >= ram_lat) ? ACCESS : BUSY;
  assign bus.ramload  = data_of(bus.ramaddr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void push(input bit is_d, input bit wr, input logic [31:0] a,
                               input logic [31:0] d, input int s);
    exp_t e;
    e.is_d = is_d; e.wr = wr; e.addr = a; e.data = d; e.streak = s;
    sb.push_back(e);
  endfunction

  // Completion monitor: pops the scoreboard on every wait-low pulse
  always @(negedge CLK) begin
    exp_t e;
    if (nRST) begin
      if (bus.ramREN) cnt_ren++;
      if (bus.ramWEN) cnt_wen++;
      if (!bus.iwait) cnt_ilow++;
      if (!bus.dwait) cnt_dlow++;
      chk("wait_excl", 32'(bus.iwait | bus.dwait), 32'd1);
      if (dut.r_state == IDLE) chk("idle_waits", 32'({bus.iwait, bus.dwait}), 32'd3);
      if (!bus.iwait || !bus.dwait) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("pulse_kind", 32'(!bus.dwait), 32'(e.is_d));
          chk("ram_addr", bus.ramaddr, e.addr);
          if (e.is_d && e.wr) begin
            chk("ram_store", bus.ramstore, e.data);
            chk("ram_wen", 32'(bus.ramWEN), 32'd1);
          end else if (e.is_d) begin
            chk("dload", bus.dload, e.data);
          end else begin
            chk("iload", bus.iload, e.data);
          end
          chk("dstreak", 32'(dut.u_streak.r_cnt), 32'(e.streak));
        end
      end
    end
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic wait_size(input int n, input int budget, input string tag);
    int k = 0;
    while (sb.size() > n && k < budget) begin
      step();
      k++;
    end
    chk(tag, 32'(sb.size()), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, c2, c3;
    nRST = 1'b0;
    bus.iREN = 1'b0; bus.iaddr = '0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
    repeat (3) step();

    // Reset state
    chk("rst_iwait", 32'(bus.iwait), 32'd1);
    chk("rst_dwait", 32'(bus.dwait), 32'd1);
    chk("rst_ramREN", 32'(bus.ramREN), 32'd0);
    chk("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
    chk("rst_ramaddr", bus.ramaddr, 32'd0);
    chk("rst_ramstore", bus.ramstore, 32'd0);
    chk("rst_iload", bus.iload, 32'd0);
    chk("rst_dload", bus.dload, 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    chk("rst_state", 32'(dut.r_state), 32'(IDLE));
    nRST = 1'b1;
    step();

    // Single fetch, zero-latency RAM
    ram_lat = 0;
    c0 = cnt_ren; c1 = cnt_ilow; c2 = cnt_dlow;
    bus.iREN = 1'b1; bus.iaddr = 32'h0000_0040;
    push(0, 0, 32'h0000_0040, 32'h2402_0005, 0);
    wait_size(0, 10, "t1_done");
    bus.iREN = 1'b0;
    repeat (3) step();
    chk("t1_ren_cycles", 32'(cnt_ren - c0), 32'd1);
    chk("t1_iwait_cycles", 32'(cnt_ilow - c1), 32'd1);
    chk("t1_dwait_cycles", 32'(cnt_dlow - c2), 32'd0);

    // Simultaneous fetch and data read: data first
    bus.iREN = 1'b1; bus.iaddr = 32'h0000_0044;
    bus.dREN = 1'b1; bus.daddr = 32'h0000_0100;
    push(1, 0, 32'h0000_0100, data_of(32'h0000_0100), 1);
    push(0, 0, 32'h0000_0044, data_of(32'h0000_0044), 0);
    wait_size(1, 10, "t2_data_first");
    bus.dREN = 1'b0;
    wait_size(0, 10, "t2_fetch_second");
    bus.iREN = 1'b0;
    repeat (2) step();

    // Continuous writes with fetch pending: streak limit forces one fetch
    ram_lat = 1;
    bus.iREN = 1'b1; bus.iaddr = 32'h0000_0080;
    bus.dWEN = 1'b1; bus.daddr = 32'h0000_0200; bus.dstore = 32'hCAFE_0001;
    for (int i = 1; i <= 4; i++) push(1, 1, 32'h0000_0200, 32'hCAFE_0001, i);
    push(0, 0, 32'h0000_0080, data_of(32'h0000_0080), 0);
    push(1, 1, 32'h0000_0200, 32'hCAFE_0001, 1);
    push(1, 1, 32'h0000_0200, 32'hCAFE_0001, 2);
    wait_size(0, 60, "t3_streak_seq");
    bus.iREN = 1'b0; bus.dWEN = 1'b0;
    repeat (3) step();

    // Hung RAM: data write aborts after TIMEOUT cycles
    ram_hang = 1'b1;
    c0 = cnt_wen; c2 = cnt_dlow;
    bus.dWEN = 1'b1; bus.daddr = 32'h0000_0300; bus.dstore = 32'h1234_5678;
    step();
    bus.dWEN = 1'b0;
    repeat (12) step();
    chk("t4_wen_cycles", 32'(cnt_wen - c0), 32'd8);
    chk("t4_dwait_cycles", 32'(cnt_dlow - c2), 32'd0);
    chk("t4_mem_err", 32'(mem_err), 32'd1);
    chk("t4_state", 32'(dut.r_state), 32'(IDLE));

    // mem_err stays set across a later good access
    ram_hang = 1'b0; ram_lat = 2;
    bus.dREN = 1'b1; bus.daddr = 32'h0000_0104;
    push(1, 0, 32'h0000_0104, data_of(32'h0000_0104), 0);
    wait_size(0, 10, "t4b_read");
    bus.dREN = 1'b0;
    step();
    chk("t4b_mem_err_sticky", 32'(mem_err), 32'd1);

    // Reset during a stalled fetch
    ram_hang = 1'b1;
    bus.iREN = 1'b1; bus.iaddr = 32'h0000_0048;
    repeat (3) step();
    chk("t5_in_iacc", 32'(dut.r_state), 32'(IACC));
    nRST = 1'b0; bus.iREN = 1'b0;
    step();
    chk("t5_state", 32'(dut.r_state), 32'(IDLE));
    chk("t5_ramREN", 32'(bus.ramREN), 32'd0);
    chk("t5_iwait", 32'(bus.iwait), 32'd1);
    chk("t5_mem_err", 32'(mem_err), 32'd0);
    nRST = 1'b1; ram_hang = 1'b0;
    step();

    // Fetch withdrawn mid-access: no pulse, then a normal fetch
    ram_lat = 3;
    c0 = cnt_ren; c1 = cnt_ilow;
    bus.iREN = 1'b1; bus.iaddr = 32'h0000_004C;
    step();
    bus.iREN = 1'b0;
    repeat (8) step();
    chk("t6_ren_cycles", 32'(cnt_ren - c0), 32'd4);
    chk("t6_iwait_cycles", 32'(cnt_ilow - c1), 32'd0);
    chk("t6_state", 32'(dut.r_state), 32'(IDLE));
    ram_lat = 0;
    bus.iREN = 1'b1; bus.iaddr = 32'h0000_0050;
    push(0, 0, 32'h0000_0050, data_of(32'h0000_0050), 0);
    wait_size(0, 10, "t6_next_fetch");
    bus.iREN = 1'b0;
    repeat (3) step();
    c3 = sb.size();
    chk("sb_empty", 32'(c3), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
